// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, latency defaults.
package mdu_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int unsigned DEF_MULT_LAT = 5;
    localparam int unsigned DEF_DIV_LAT  = 10;
    localparam int unsigned CNT_W        = 16;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder for the selected md_op.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;

    assign prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u   = {32'b0, rs_val} * {32'b0, rt_val};
    assign div_zero = (rt_val == 32'd0);

    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        if (!div_zero) begin
            // The one signed-overflow case is pinned explicitly rather than left to the operator.
            if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                quot_s = 32'sh8000_0000;
                rem_s  = '0;
            end else begin
                quot_s = $signed(rs_val) / $signed(rt_val);
                rem_s  = $signed(rs_val) % $signed(rt_val);
            end
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_hi = rs_val % rt_val;
                    res_lo = rs_val / rt_val;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide control: latency FSM, pending result registers and architectural HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic               done_q, done_d;

    logic [31:0]        res_hi, res_lo;
    logic               div_zero;

    mdu_arith u_arith (
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_LAT);
                            state_d   = StMul;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            // Divide by zero still runs the full latency but leaves HI/LO alone.
                            pend_wr_d = ~div_zero;
                            cnt_d     = CNT_W'(DIV_LAT);
                            state_d   = StDiv;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = D_is_md & (busy | start);

endmodule
